keep_pack_buffer: RTL and testbench
===================================

KEEP_PACK_BUFFER -- requirements
Module: keep_pack_buffer

Interface
REQ-001 SHALL have parameter BUSBYTEWIDTH, default 16, giving bus width in bytes for both the input and output bus.
REQ-002 SHALL have parameter BYTESAVAIL, default 32, giving storage depth in bytes; it must be a power of two and at least 2*BUSBYTEWIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port businvld, input, 1, input beat valid.
REQ-006 SHALL have port businkeep, input, BUSBYTEWIDTH, per-byte keep, possibly sparse.
REQ-007 SHALL have port busin, input, BUSBYTEWIDTH*8, input data; byte k is bits [8k+7:8k].
REQ-008 SHALL have port flushin, input, 1, a one-cycle request to drain a partial word.
REQ-009 SHALL have port bytesavailout, output, $clog2(BYTESAVAIL)+1, free storage in bytes.
REQ-010 SHALL have port overflow, output, 1, a one-cycle pulse when kept bytes were dropped.
REQ-011 SHALL have port busoutrdy, input, 1, downstream ready.
REQ-012 SHALL have port busoutvld, output, 1, output word valid.
REQ-013 SHALL have port busoutkeep, output, BUSBYTEWIDTH, output keep; always thermometer-coded from byte 0.
REQ-014 SHALL have port busout, output, BUSBYTEWIDTH*8, output data; compacted bytes in arrival order.

Function
REQ-015 SHALL hold internal state: byte storage[BYTESAVAIL], wrptr and rdptr (each $clog2(BYTESAVAIL) bits), fill counter ($clog2(BYTESAVAIL)+1 bits), and state register in {FILL, DRAIN}.
REQ-016 SHALL drive bytesavailout = BYTESAVAIL - fill at all times, derived from registered fill only.
REQ-017 SHALL accept, on a businvld cycle, the set keep bytes in ascending byte-index order, packed contiguously starting at wrptr; unkept bytes are discarded.
REQ-018 SHALL limit write capacity in a cycle to the free space at the start of that cycle; bytes freed by a same-cycle pop are not credited until the next cycle.
REQ-019 SHALL, when popcount(businkeep) exceeds free space, write only the lowest-indexed kept bytes up to the free space, drop the remainder, and assert overflow for the following cycle only.
REQ-020 SHALL treat businkeep==0 with businvld=1 as a no-op with no overflow.
REQ-021 SHALL ignore businkeep and busin when businvld=0.
REQ-022 SHALL wrap wrptr and rdptr modulo BYTESAVAIL; a word whose bytes straddle the wrap point is read and written correctly.
REQ-023 SHALL, in state FILL, assert busoutvld iff fill >= BUSBYTEWIDTH, with busoutkeep all ones.
REQ-024 SHALL, in state DRAIN, assert busoutvld iff fill > 0, with busoutkeep = (1<<min(fill,BUSBYTEWIDTH))-1.
REQ-025 SHALL present busout byte k = storage[(rdptr+k) mod BYTESAVAIL] for each kept k, and zero for each unkept byte.
REQ-026 SHALL perform a pop when busoutvld && busoutrdy at the clock edge: rdptr and fill advance by popcount(busoutkeep).
REQ-027 SHALL update fill as fill + written - popped; simultaneous write and pop in one cycle are both honored.
REQ-028 SHALL keep busoutvld, busoutkeep and busout stable while busoutvld=1 and busoutrdy=0, apart from busoutkeep growth in DRAIN caused by new writes.
REQ-029 SHALL take the FILL->DRAIN transition on flushin=1 when fill or the same-cycle write count is nonzero; otherwise flushin is ignored.
REQ-030 SHALL take the DRAIN->FILL transition when next-cycle fill equals 0; flushin in DRAIN is ignored.
REQ-031 SHALL accept writes normally in DRAIN; drain ends only at empty.
REQ-032 SHALL make accepted bytes eligible for output starting the cycle after the write; there is no combinational path from businvld to busoutvld.

Reset
REQ-033 SHALL, when reset is high at a clock edge, set fill=0, wrptr=0, rdptr=0, state=FILL, overflow=0; hence busoutvld=0, busoutkeep=0, busout=0, and bytesavailout=BYTESAVAIL the next cycle.
REQ-034 SHALL abandon any write, pop or drain in progress on reset mid-operation; storage contents need not be cleared.

Verification
REQ-035 SHALL cover reset: assert reset 2 cycles -> bytesavailout=32, busoutvld=0, overflow=0.
REQ-036 SHALL cover sparse packing: two beats keep=16'hA5A5, data bytes 0x00..0x0F each -> bytesavailout=16, then busoutvld=1, busoutkeep=16'hFFFF, busout bytes = {00,02,05,07,08,0A,0D,0F} twice in order.
REQ-037 SHALL cover overflow: fill=24, write keep=16'hFFFF -> 8 lowest bytes stored, overflow pulses 1 cycle, bytesavailout=0.
REQ-038 SHALL cover flush: fill=5, flushin pulse, busoutrdy=1 -> busoutvld=1 with busoutkeep=16'h001F, then fill=0, state FILL, busoutvld=0.
REQ-039 SHALL cover wrap: 10 full-keep beats with busoutrdy=1 throughout -> output data matches input sequence across pointer wrap with no loss.
REQ-040 SHALL cover concurrent traffic: fill=32, pop and write keep=16'hFFFF in the same cycle -> write dropped with overflow=1, fill=16 afterwards.

Source files
------------

// File: rtl/keep_pack_buffer.sv
// Keep-mask packing buffer: compacts sparse input bytes into a circular byte store
// and emits full words, or partial thermometer-keep words while draining after a flush.
module keep_pack_buffer #(
    parameter int unsigned BUSBYTEWIDTH = 16,
    parameter int unsigned BYTESAVAIL   = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            businvld,
    input  logic [BUSBYTEWIDTH-1:0]         businkeep,
    input  logic [BUSBYTEWIDTH*8-1:0]       busin,
    input  logic                            flushin,
    output logic [$clog2(BYTESAVAIL):0]     bytesavailout,
    output logic                            overflow,
    input  logic                            busoutrdy,
    output logic                            busoutvld,
    output logic [BUSBYTEWIDTH-1:0]         busoutkeep,
    output logic [BUSBYTEWIDTH*8-1:0]       busout
);

    localparam int unsigned PW = $clog2(BYTESAVAIL);
    localparam int unsigned FW = PW + 1;
    localparam int unsigned BW = BUSBYTEWIDTH;

    localparam logic [FW-1:0] DEPTH = FW'(BYTESAVAIL);
    localparam logic [FW-1:0] WORD  = FW'(BUSBYTEWIDTH);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [7:0]    storage [BYTESAVAIL];
    logic [PW-1:0] wrptr;
    logic [PW-1:0] rdptr;
    logic [FW-1:0] fill;
    logic [0:0]    state;
    logic [0:0]    state_next;

    logic [FW-1:0] free;
    logic [FW-1:0] kcnt;
    logic [FW-1:0] offs [BW];
    logic [BW-1:0] wr_en;
    logic [FW-1:0] wr_cnt;
    logic          drop;
    logic [FW-1:0] out_cnt;
    logic [FW-1:0] pop_cnt;
    logic [FW-1:0] fill_next;

    assign bytesavailout = DEPTH - fill;

    // Output word: thermometer keep of out_cnt bytes starting at rdptr
    always_comb begin
        out_cnt    = '0;
        busoutkeep = '0;
        busout     = '0;
        if (state == FILL) begin
            out_cnt = (fill >= WORD) ? WORD : '0;
        end else begin
            out_cnt = (fill < WORD) ? fill : WORD;
        end
        for (int k = 0; k < BW; k++) begin
            if (FW'(k) < out_cnt) begin
                busoutkeep[k]  = 1'b1;
                busout[8*k +: 8] = storage[PW'(rdptr + PW'(k))];
            end
        end
        busoutvld = (out_cnt != '0);
        pop_cnt   = (busoutvld && busoutrdy) ? out_cnt : '0;
    end

    // Compaction: each kept byte lands at wrptr plus the number of kept bytes below it,
    // capped by the free space registered at the start of the cycle
    always_comb begin
        free  = DEPTH - fill;
        kcnt  = '0;
        wr_en = '0;
        for (int k = 0; k < BW; k++) begin
            offs[k] = kcnt;
            if (businvld && businkeep[k]) begin
                wr_en[k] = (kcnt < free);
                kcnt     = kcnt + FW'(1);
            end
        end
        drop      = (kcnt > free);
        wr_cnt    = drop ? free : kcnt;
        fill_next = fill + wr_cnt - pop_cnt;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (flushin && ((fill != '0) || (wr_cnt != '0))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fill_next == '0) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrptr    <= '0;
            rdptr    <= '0;
            fill     <= '0;
            overflow <= 1'b0;
            state    <= FILL;
        end else begin
            wrptr    <= wrptr + PW'(wr_cnt);
            rdptr    <= rdptr + PW'(pop_cnt);
            fill     <= fill_next;
            overflow <= drop;
            state    <= state_next;
        end
    end

    // Byte store carries no reset; pointers and fill define what is valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < BW; k++) begin
                if (wr_en[k]) begin
                    storage[PW'(wrptr + PW'(offs[k]))] <= busin[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_keep_pack_buffer.sv
// Bench for keep_pack_buffer: directed scenarios then random traffic, all outputs
// compared each cycle against a byte-queue reference model.
module tb_keep_pack_buffer;

    localparam int unsigned BW = 16;
    localparam int unsigned BA = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          businvld;
    logic [BW-1:0] businkeep;
    logic [BW*8-1:0] busin;
    logic          flushin;
    logic [5:0]    bytesavailout;
    logic          overflow;
    logic          busoutrdy;
    logic          busoutvld;
    logic [BW-1:0] busoutkeep;
    logic [BW*8-1:0] busout;

    always #5 clk = ~clk;

    keep_pack_buffer #(.BUSBYTEWIDTH(BW), .BYTESAVAIL(BA)) dut (
        .clk           (clk),
        .reset         (reset),
        .businvld      (businvld),
        .businkeep     (businkeep),
        .busin         (busin),
        .flushin       (flushin),
        .bytesavailout (bytesavailout),
        .overflow      (overflow),
        .busoutrdy     (busoutrdy),
        .busoutvld     (busoutvld),
        .busoutkeep    (busoutkeep),
        .busout        (busout)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: bytes held, in arrival order
    logic [7:0] mq[$];
    bit         m_drain = 1'b0;
    bit         m_ovf   = 1'b0;
    bit         m_known = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] ramp(input int base);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < BW; i++) d[8*i +: 8] = 8'((base + i) & 8'hFF);
        return d;
    endfunction

    // Called at a negedge: check outputs, drive inputs, advance model, return at next negedge
    task automatic step(input logic rst, input logic v, input logic [15:0] k,
                        input logic [127:0] d, input logic fl, input logic rd);
        int n, cnt, free, kept, wr;
        logic [15:0]  ek;
        logic [127:0] eb;
        n = mq.size();
        cnt = 0;
        if (m_known) begin
            if (m_drain) cnt = (n < BW) ? n : BW;
            else         cnt = (n >= BW) ? BW : 0;
            ek = '0;
            eb = '0;
            for (int i = 0; i < cnt; i++) begin
                ek[i] = 1'b1;
                eb[8*i +: 8] = mq[i];
            end
            chk("avail", 128'(bytesavailout), 128'(BA - n));
            chk("vld",   128'(busoutvld),     128'(cnt > 0));
            chk("keep",  128'(busoutkeep),    128'(ek));
            chk("data",  busout,              eb);
            chk("ovf",   128'(overflow),      128'(m_ovf));
        end
        reset     = rst;
        businvld  = v;
        businkeep = k;
        busin     = d;
        flushin   = fl;
        busoutrdy = rd;
        if (rst) begin
            mq.delete();
            m_drain = 1'b0;
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            free = BA - n;
            if (cnt > 0 && rd) repeat (cnt) void'(mq.pop_front());
            kept = 0;
            wr   = 0;
            if (v) begin
                for (int i = 0; i < BW; i++) begin
                    if (k[i]) begin
                        kept++;
                        if (wr < free) begin
                            mq.push_back(d[8*i +: 8]);
                            wr++;
                        end
                    end
                end
            end
            m_ovf = (kept > free);
            if (!m_drain) begin
                if (fl && (n != 0 || wr != 0)) m_drain = 1'b1;
            end else if (mq.size() == 0) begin
                m_drain = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rd);
        step(1'b0, 1'b0, 16'h0000, '0, 1'b0, rd);
    endtask

    initial begin
        reset = 1'b1; businvld = 1'b0; businkeep = '0; busin = '0;
        flushin = 1'b0; busoutrdy = 1'b0;
        @(negedge clk);

        // Reset held two cycles
        step(1'b1, 1'b0, 16'h0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, '0, 1'b0, 1'b0);
        chk("rst_avail", 128'(bytesavailout), 128'd32);
        chk("rst_vld",   128'(busoutvld),     128'd0);
        chk("rst_ovf",   128'(overflow),      128'd0);

        // Sparse packing
        step(1'b0, 1'b1, 16'hA5A5, ramp(0), 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hA5A5, ramp(0), 1'b0, 1'b0);
        chk("sp_avail", 128'(bytesavailout), 128'd16);
        chk("sp_vld",   128'(busoutvld),     128'd1);
        chk("sp_keep",  128'(busoutkeep),    128'hFFFF);
        chk("sp_data",  busout, 128'h0F0D0A08070502000F0D0A0807050200);
        idle(1'b1);

        // Overflow at fill=24, then simultaneous pop and write when full
        step(1'b0, 1'b1, 16'hFFFF, ramp(8'h20), 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h00FF, ramp(8'h30), 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hFFFF, ramp(8'h40), 1'b0, 1'b0);
        chk("ov_avail", 128'(bytesavailout), 128'd0);
        chk("ov_flag",  128'(overflow),      128'd1);
        step(1'b0, 1'b1, 16'hFFFF, ramp(8'h50), 1'b0, 1'b1);
        chk("cc_avail", 128'(bytesavailout), 128'd16);
        chk("cc_ovf",   128'(overflow),      128'd1);
        chk("cc_data",  busout, 128'h47464544434241403736353433323130);
        idle(1'b1);
        chk("cc_ovf_end", 128'(overflow), 128'd0);

        // Flush of a 5-byte partial word
        step(1'b0, 1'b1, 16'h001F, ramp(8'h60), 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0000, '0, 1'b1, 1'b1);
        chk("fl_vld",  128'(busoutvld),  128'd1);
        chk("fl_keep", 128'(busoutkeep), 128'h001F);
        chk("fl_data", busout, 128'h6463626160);
        idle(1'b1);
        chk("fl_empty", 128'(busoutvld),     128'd0);
        chk("fl_avail", 128'(bytesavailout), 128'd32);
        step(1'b0, 1'b1, 16'h001F, ramp(8'h70), 1'b0, 1'b1);
        chk("fl_back_to_fill", 128'(busoutvld), 128'd0);
        step(1'b0, 1'b0, 16'h0000, '0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Pointer wrap under continuous full-keep traffic
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'hFFFF, ramp(8'h80 + 16*i), 1'b0, 1'b1);
        repeat (3) idle(1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic          v, fl, rd, rs;
            logic [15:0]   k;
            logic [127:0]  d;
            int            sel;
            sel = $urandom_range(0, 3);
            k   = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
            d   = {$urandom, $urandom, $urandom, $urandom};
            v   = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            rd  = ($urandom_range(0, 2) != 0);
            rs  = ($urandom_range(0, 249) == 0);
            step(rs, v, k, d, fl, rd);
        end
        step(1'b0, 1'b0, 16'h0, '0, 1'b1, 1'b1);
        repeat (4) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
